// File: rtl/mm_pkg.sv
// Shared Mastermind datapath types: game state, default geometry, history entry layout.
package mm_pkg;

  localparam int unsigned MM_PEGS    = 4;
  localparam int unsigned MM_COLOR_W = 3;
  localparam int unsigned MM_DEPTH   = 8;
  localparam int unsigned MM_FB_W    = $clog2(MM_PEGS + 1);
  localparam int unsigned MM_TURN_W  = $clog2(MM_DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PLAY  = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [MM_PEGS*MM_COLOR_W-1:0] guess;
    logic [MM_FB_W-1:0]            exact;
    logic [MM_FB_W-1:0]            near;
  } entry_t;

endpackage

// File: rtl/guess_history_mem.sv
// DEPTH x entry register file: synchronous write, registered read, synchronous clear.
module guess_history_mem #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENTRY_W = 18,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  input  logic               rvalid,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Storage array; clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port returns zero whenever nothing is selectable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rvalid) begin
      rdata <= mem_q[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/guess_history_buf.sv
// Guess/feedback history for Mastermind: records scored turns, tracks game
// progress and lets the player browse past turns for the display path.
module guess_history_buf
  import mm_pkg::*;
#(
  parameter int unsigned PEGS    = MM_PEGS,
  parameter int unsigned COLOR_W = MM_COLOR_W,
  parameter int unsigned DEPTH   = MM_DEPTH,
  parameter int unsigned TURN_W  = $clog2(DEPTH),
  parameter int unsigned FB_W    = $clog2(PEGS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      mode,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      store,
  input  logic [PEGS*COLOR_W-1:0]   guess,
  input  logic [FB_W-1:0]           fb_exact,
  input  logic [FB_W-1:0]           fb_near,
  output logic [PEGS*COLOR_W-1:0]   sel_guess,
  output logic [FB_W-1:0]           sel_exact,
  output logic [FB_W-1:0]           sel_near,
  output logic [TURN_W-1:0]         sel_turn,
  output logic                      sel_valid,
  output logic [TURN_W:0]           count,
  output logic                      last_turn,
  output logic                      solved,
  output logic                      done
);

  localparam int unsigned CNT_W = TURN_W + 1;

  typedef struct packed {
    logic [PEGS*COLOR_W-1:0] guess;
    logic [FB_W-1:0]         exact;
    logic [FB_W-1:0]         near;
  } hist_entry_t;

  localparam int unsigned ENTRY_W = $bits(hist_entry_t);

  state_e            state_q;
  logic [TURN_W-1:0] cursor_q;
  hist_entry_t       wr_entry_c;
  hist_entry_t       rd_entry;
  logic              accept_c;
  logic              win_c;
  logic              has_data_c;
  logic [CNT_W-1:0]  count_inc_c;
  logic [TURN_W-1:0] last_idx_c;

  always_comb begin
    has_data_c  = (count != '0);
    accept_c    = store && !mode && (state_q != S_DONE) && !clear;
    win_c       = (fb_exact == FB_W'(PEGS));
    count_inc_c = count + 1'b1;
    last_idx_c  = has_data_c ? TURN_W'(count - 1'b1) : '0;
    wr_entry_c  = '{guess: guess, exact: fb_exact, near: fb_near};
  end

  // Game FSM with count, cursor and flags; clear overrides store and buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_EMPTY;
      count     <= '0;
      cursor_q  <= '0;
      solved    <= 1'b0;
      last_turn <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      state_q   <= S_EMPTY;
      count     <= '0;
      cursor_q  <= '0;
      solved    <= 1'b0;
      last_turn <= 1'b0;
      done      <= 1'b0;
    end else if (accept_c) begin
      count     <= count_inc_c;
      cursor_q  <= TURN_W'(count);
      solved    <= solved | win_c;
      last_turn <= (count_inc_c == CNT_W'(DEPTH - 1));
      if (win_c || (count_inc_c == CNT_W'(DEPTH))) begin
        state_q <= S_DONE;
        done    <= 1'b1;
      end else begin
        state_q <= S_PLAY;
        done    <= 1'b0;
      end
    end else if (!mode) begin
      cursor_q <= last_idx_c;
    end else if (has_data_c) begin
      // Browse: saturating moves, simultaneous presses cancel.
      if (btn_up && !btn_down && (cursor_q != last_idx_c)) begin
        cursor_q <= cursor_q + 1'b1;
      end else if (btn_down && !btn_up && (cursor_q != '0)) begin
        cursor_q <= cursor_q - 1'b1;
      end
    end
  end

  guess_history_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .ADDR_W  (TURN_W)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .we     (accept_c),
    .waddr  (TURN_W'(count)),
    .wdata  (wr_entry_c),
    .raddr  (cursor_q),
    .rvalid (has_data_c),
    .rdata  (rd_entry)
  );

  // Turn index and valid flag follow the read data by the same one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_turn  <= '0;
      sel_valid <= 1'b0;
    end else begin
      sel_turn  <= has_data_c ? cursor_q : '0;
      sel_valid <= has_data_c;
    end
  end

  assign sel_guess = rd_entry.guess;
  assign sel_exact = rd_entry.exact;
  assign sel_near  = rd_entry.near;

endmodule

// File: tb/tb_guess_history_buf.sv
// Scoreboarded bench for guess_history_buf at default geometry (4 pegs, 3-bit colours, depth 8).
module tb_guess_history_buf;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        mode;
  logic        btn_up;
  logic        btn_down;
  logic        store;
  logic [11:0] guess;
  logic [2:0]  fb_exact;
  logic [2:0]  fb_near;
  logic [11:0] sel_guess;
  logic [2:0]  sel_exact;
  logic [2:0]  sel_near;
  logic [2:0]  sel_turn;
  logic        sel_valid;
  logic [3:0]  count;
  logic        last_turn;
  logic        solved;
  logic        done;

  typedef struct packed {
    logic [11:0] guess;
    logic [2:0]  exact;
    logic [2:0]  near;
    logic [2:0]  turn;
    logic        valid;
  } sel_t;

  sel_t        exp_q[$];
  sel_t        exp_s;
  sel_t        obs_s;
  logic [11:0] hist_g [8];
  int          n_cmp  = 0;
  int          n_fail = 0;

  guess_history_buf dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .mode      (mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .store     (store),
    .guess     (guess),
    .fb_exact  (fb_exact),
    .fb_near   (fb_near),
    .sel_guess (sel_guess),
    .sel_exact (sel_exact),
    .sel_near  (sel_near),
    .sel_turn  (sel_turn),
    .sel_valid (sel_valid),
    .count     (count),
    .last_turn (last_turn),
    .solved    (solved),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sel_t observe();
    return '{guess: sel_guess, exact: sel_exact, near: sel_near, turn: sel_turn, valid: sel_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [11:0] g, input logic [2:0] e, input logic [2:0] n);
    guess = g; fb_exact = e; fb_near = n; store = 1'b1;
    tick();
    store = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up = up; btn_down = dn;
    tick();
    btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic test_reset();
    clear = 0; mode = 0; btn_up = 0; btn_down = 0; store = 0;
    guess = '0; fb_exact = '0; fb_near = '0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({count, last_turn, solved, done} !== 7'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000000", {count, last_turn, solved, done});
    end
    obs_s = observe();
    n_cmp++;
    if (obs_s !== '0) begin
      n_fail++; $display("FAIL reset_sel: got %h want 0", obs_s);
    end
  endtask

  task automatic test_first_store();
    do_store(12'h123, 3'd1, 3'd2);
    exp_q.push_back('{guess: 12'h123, exact: 3'd1, near: 3'd2, turn: 3'd0, valid: 1'b1});
    n_cmp++;
    if (count !== 4'd1 || done !== 1'b0 || solved !== 1'b0) begin
      n_fail++; $display("FAIL first_count: got count=%0d done=%b solved=%b want 1/0/0", count, done, solved);
    end
    obs_s = observe();
    n_cmp++;
    if (obs_s.valid !== 1'b0) begin
      n_fail++; $display("FAIL first_latency: sel_valid got %b want 0 before read cycle", obs_s.valid);
    end
    tick();
    exp_s = exp_q.pop_front();
    obs_s = observe();
    n_cmp++;
    if (obs_s !== exp_s) begin
      n_fail++; $display("FAIL first_sel: got %h want %h", obs_s, exp_s);
    end
  endtask

  task automatic test_fill();
    do_clear();
    for (int i = 0; i < 9; i++) begin
      hist_g[i % 8] = (i < 8) ? 12'(12'h200 + i * 12'h011) : hist_g[i % 8];
      do_store(12'(12'h200 + i * 12'h011), 3'd1, 3'd1);
      if (i == 5) begin
        n_cmp++;
        if (last_turn !== 1'b0 || count !== 4'd6) begin
          n_fail++; $display("FAIL fill_6: got last_turn=%b count=%0d want 0/6", last_turn, count);
        end
      end else if (i == 6) begin
        n_cmp++;
        if (last_turn !== 1'b1 || count !== 4'd7 || done !== 1'b0) begin
          n_fail++; $display("FAIL fill_7: got last_turn=%b count=%0d done=%b want 1/7/0", last_turn, count, done);
        end
      end else if (i == 7) begin
        exp_q.push_back('{guess: hist_g[7], exact: 3'd1, near: 3'd1, turn: 3'd7, valid: 1'b1});
        n_cmp++;
        if (count !== 4'd8 || done !== 1'b1 || solved !== 1'b0 || last_turn !== 1'b0) begin
          n_fail++; $display("FAIL fill_8: got count=%0d done=%b solved=%b last=%b want 8/1/0/0", count, done, solved, last_turn);
        end
      end else if (i == 8) begin
        n_cmp++;
        if (count !== 4'd8) begin
          n_fail++; $display("FAIL fill_9_ignored: got count=%0d want 8", count);
        end
      end
    end
    exp_s = exp_q.pop_front();
    obs_s = observe();
    n_cmp++;
    if (obs_s !== exp_s) begin
      n_fail++; $display("FAIL fill_sel: got %h want %h", obs_s, exp_s);
    end
  endtask

  task automatic test_solve();
    do_clear();
    for (int i = 0; i < 3; i++) do_store(12'(12'h300 + i), 3'd2, 3'd0);
    do_store(12'h3AB, 3'd4, 3'd0);
    exp_q.push_back('{guess: 12'h3AB, exact: 3'd4, near: 3'd0, turn: 3'd3, valid: 1'b1});
    n_cmp++;
    if (solved !== 1'b1 || done !== 1'b1 || count !== 4'd4) begin
      n_fail++; $display("FAIL solve_flags: got solved=%b done=%b count=%0d want 1/1/4", solved, done, count);
    end
    do_store(12'h3CD, 3'd1, 3'd1);
    exp_s = exp_q.pop_front();
    obs_s = observe();
    n_cmp++;
    if (obs_s !== exp_s) begin
      n_fail++; $display("FAIL solve_sel: got %h want %h", obs_s, exp_s);
    end
    n_cmp++;
    if (count !== 4'd4 || solved !== 1'b1) begin
      n_fail++; $display("FAIL solve_locked: got count=%0d solved=%b want 4/1", count, solved);
    end
  endtask

  task automatic test_browse();
    int exp_dn [6] = '{3, 2, 1, 0, 0, 0};
    int exp_up [6] = '{1, 2, 3, 4, 4, 4};
    do_clear();
    for (int i = 0; i < 5; i++) begin
      hist_g[i] = 12'(12'h400 + i * 12'h021);
      do_store(hist_g[i], 3'(i % 4), 3'(4 - i % 4));
    end
    mode = 1'b1;
    tick(); tick();
    n_cmp++;
    if (sel_turn !== 3'd4 || sel_guess !== hist_g[4]) begin
      n_fail++; $display("FAIL browse_enter: got turn=%0d guess=%h want 4/%h", sel_turn, sel_guess, hist_g[4]);
    end
    for (int k = 0; k < 12; k++) begin
      int t;
      t = (k < 6) ? exp_dn[k] : exp_up[k - 6];
      press(k >= 6, k < 6);
      exp_q.push_back('{guess: hist_g[t], exact: 3'(t % 4), near: 3'(4 - t % 4), turn: 3'(t), valid: 1'b1});
      tick();
      exp_s = exp_q.pop_front();
      obs_s = observe();
      n_cmp++;
      if (obs_s !== exp_s) begin
        n_fail++; $display("FAIL browse_step%0d: got %h want %h", k, obs_s, exp_s);
      end
    end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    tick();
    n_cmp++;
    if (sel_turn !== 3'd2) begin
      n_fail++; $display("FAIL browse_both: got turn=%0d want 2", sel_turn);
    end
    mode = 1'b0;
    tick(); tick();
    n_cmp++;
    if (sel_turn !== 3'd4 || sel_guess !== hist_g[4]) begin
      n_fail++; $display("FAIL browse_exit: got turn=%0d guess=%h want 4/%h", sel_turn, sel_guess, hist_g[4]);
    end
  endtask

  task automatic test_ignored_and_clear();
    mode = 1'b1;
    do_store(12'hABC, 3'd1, 3'd0);
    n_cmp++;
    if (count !== 4'd5) begin
      n_fail++; $display("FAIL browse_store: got count=%0d want 5", count);
    end
    mode = 1'b0;
    clear = 1'b1;
    do_store(12'hDEF, 3'd1, 3'd0);
    clear = 1'b0;
    n_cmp++;
    if ({count, last_turn, solved, done} !== 7'd0) begin
      n_fail++; $display("FAIL clear_store_flags: got %b want 0000000", {count, last_turn, solved, done});
    end
    tick();
    obs_s = observe();
    n_cmp++;
    if (obs_s !== '0) begin
      n_fail++; $display("FAIL clear_store_sel: got %h want 0", obs_s);
    end
    mode = 1'b1;
    press(1'b1, 1'b0);
    tick();
    obs_s = observe();
    n_cmp++;
    if (obs_s !== '0) begin
      n_fail++; $display("FAIL empty_browse: got %h want 0", obs_s);
    end
    mode = 1'b0;
  endtask

  task automatic test_async_reset();
    do_store(12'h555, 3'd2, 3'd1);
    do_store(12'h666, 3'd0, 3'd3);
    tick();
    #2 reset = 1'b0;
    #1;
    obs_s = observe();
    n_cmp++;
    if (obs_s !== '0 || {count, last_turn, solved, done} !== 7'd0) begin
      n_fail++; $display("FAIL async_reset: got sel=%h flags=%b want 0/0", obs_s, {count, last_turn, solved, done});
    end
    tick();
    #3 reset = 1'b1;
    tick(); tick();
    obs_s = observe();
    n_cmp++;
    if (obs_s !== '0 || count !== 4'd0) begin
      n_fail++; $display("FAIL post_reset: got sel=%h count=%0d want 0/0", obs_s, count);
    end
    do_store(12'h777, 3'd3, 3'd0);
    exp_q.push_back('{guess: 12'h777, exact: 3'd3, near: 3'd0, turn: 3'd0, valid: 1'b1});
    tick();
    exp_s = exp_q.pop_front();
    obs_s = observe();
    n_cmp++;
    if (obs_s !== exp_s || count !== 4'd1) begin
      n_fail++; $display("FAIL post_reset_store: got %h count=%0d want %h count=1", obs_s, count, exp_s);
    end
  endtask

  initial begin
    test_reset();
    test_first_store();
    test_fill();
    test_solve();
    test_browse();
    test_ignored_and_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
